serial_add_sched: RTL and testbench

SERIAL_ADD_SCHED -- requirements
Module: serial_add_sched

---
 rtl/serial_add_sched_pkg.sv | 14 +
 rtl/serial_add_sched_adder.sv | 16 +
 rtl/serial_add_sched.sv | 160 ++++++++++++++++
 tb/tb_serial_add_sched.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_sched_pkg.sv
// Shared definitions for the serial adder family: FSM encoding and
// default slice geometry.
package serial_add_sched_pkg;

    localparam int unsigned DEFAULT_N      = 8;
    localparam int unsigned DEFAULT_CHUNKS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_sched_adder.sv
// Plain WIDTH-bit adder with carry out and no carry in.
module adderNbit_carry #(
    parameter int unsigned WIDTH = 9
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Zero-extend both operands so the top bit of the result is the carry.
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b};
    end

endmodule

// File: rtl/serial_add_sched.sv
// Two-requester W-bit adder that shares a single N-bit slice, processing
// one chunk per cycle (LSB first) under round-robin arbitration.
module serial_add_sched
    import serial_add_sched_pkg::*;
#(
    parameter  int unsigned N      = DEFAULT_N,
    parameter  int unsigned CHUNKS = DEFAULT_CHUNKS,
    localparam int unsigned W      = N * CHUNKS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         req1_ready,
    output logic         rsp_valid,
    output logic         rsp_id,
    output logic [W-1:0] rsp_sum,
    output logic         rsp_cout,
    input  logic         rsp_ready
);

    localparam int unsigned    KW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [KW-1:0]  K_LAST = KW'(CHUNKS - 1);
    localparam logic [W-1:0]   CHUNK_MASK = W'({N{1'b1}});

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            id_q, id_d;
    logic            last_q, last_d;

    logic            any_req;
    logic            gnt_id;
    logic            idle_open;
    int unsigned     shamt;
    logic [N-1:0]    a_chunk;
    logic [N-1:0]    b_chunk;
    logic [N:0]      adder_a;
    logic [N:0]      adder_b;
    logic [N:0]      adder_sum;
    logic            adder_cout;
    logic            adder_lsb_unused;

    // Round-robin grant: on contention the requester not granted last wins.
    always_comb begin
        any_req = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            gnt_id = ~last_q;
        end else begin
            gnt_id = req1_valid;
        end
        idle_open  = rst_n && (state_q == ST_IDLE) && any_req;
        req0_ready = idle_open && !gnt_id;
        req1_ready = idle_open && gnt_id;
    end

    // Select the current chunk and build the carry-injecting adder operands.
    always_comb begin
        shamt   = 32'(k_q) * N;
        a_chunk = N'(a_q >> shamt);
        b_chunk = N'(b_q >> shamt);
        // With carry in the LSB of both operands, bit 0 sums to 2*carry,
        // which ripples into bit 1; sum[N:1] is then a_chunk+b_chunk+carry.
        adder_a = {a_chunk, carry_q};
        adder_b = {b_chunk, carry_q};
    end

    adderNbit_carry #(
        .WIDTH (N + 1)
    ) u_slice (
        .a    (adder_a),
        .b    (adder_b),
        .sum  (adder_sum),
        .cout (adder_cout)
    );

    // Bit 0 of the slice result only absorbs the injected carry.
    assign adder_lsb_unused = adder_sum[0];

    // Next-state and datapath update for IDLE/BUSY/DONE.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        id_d    = id_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    a_d     = gnt_id ? req1_a : req0_a;
                    b_d     = gnt_id ? req1_b : req0_b;
                    id_d    = gnt_id;
                    last_d  = gnt_id;
                    carry_d = 1'b0;
                    k_d     = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                sum_d   = (sum_q & ~(CHUNK_MASK << shamt))
                        | (W'(adder_sum[N:1]) << shamt);
                carry_d = adder_cout;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    assign rsp_valid = rst_n && (state_q == ST_DONE);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = carry_q;

endmodule

// File: tb/tb_serial_add_sched.sv
// Scoreboard bench for serial_add_sched (N=8, CHUNKS=4).
module tb_serial_add_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_id, rsp_cout, rsp_ready;
    logic [31:0] rsp_sum;

    typedef struct packed {
        logic        id;
        logic [31:0] sum;
        logic        cout;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_sum  [2];
    logic        exp_cout [2];

    always #5 clk = ~clk;

    serial_add_sched #(
        .N      (8),
        .CHUNKS (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .rsp_ready  (rsp_ready)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Monitor: every response handshake pops and compares one expected item.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_rsp: got id=%0d sum=0x%0h, expected no response",
                             rsp_id, rsp_sum);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id",   rsp_id,   e.id);
                    check("rsp_sum",  rsp_sum,  e.sum);
                    check("rsp_cout", rsp_cout, e.cout);
                end
            end
        end
    end

    task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] s, input logic c);
        exp_sum[id]  = s;
        exp_cout[id] = c;
        if (id) begin
            req1_a = a; req1_b = b; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_valid = 1'b1;
        end
    endtask

    // Wait (bounded) for the acceptance edge of requester id; returns #1 after it.
    task automatic await_accept(input bit id, input bit push);
        bit ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin
                check("other_ready_low", id ? req0_ready : req1_ready, 0);
                @(posedge clk);
                #1;
                if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
                if (push) sb.push_back({id, exp_sum[id], exp_cout[id]});
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: got no ready for req%0d, expected acceptance", id);
        end
    endtask

    // Called #1 after acceptance: latency, optional hold in DONE, then take.
    task automatic complete(input bit id, input int hold);
        int lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
        check("latency", lat, 4);
        for (int h = 0; h < hold; h++) begin
            check("hold_valid",  rsp_valid,  1);
            check("hold_ready0", req0_ready, 0);
            check("hold_ready1", req1_ready, 0);
            check("hold_id",     rsp_id,     id);
            check("hold_sum",    rsp_sum,    exp_sum[id]);
            check("hold_cout",   rsp_cout,   exp_cout[id]);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("idle_after_take", rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit seen;
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;

        // Contending pair presented while reset is held: readies must stay low.
        issue(0, 32'h12345678, 32'h87654321, 32'h99999999, 1'b0);
        issue(1, 32'h12345678, 32'h87654321, 32'h99999999, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready0",    req0_ready, 0);
        check("rst_ready1",    req1_ready, 0);
        check("rst_rsp_valid", rsp_valid,  0);
        check("rst_rsp_sum",   rsp_sum,    0);
        check("rst_rsp_id",    rsp_id,     0);
        check("rst_rsp_cout",  rsp_cout,   0);
        rst_n = 1'b1;

        // First contention after reset: req0 first, then req1.
        await_accept(0, 1'b1);
        complete(0, 0);
        await_accept(1, 1'b1);
        complete(1, 0);

        // All-ones plus one: full carry ripple, response held 5 cycles.
        issue(1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1);
        await_accept(1, 1'b1);
        complete(1, 5);

        // Chunk boundary carry; previous cout must not leak in (0x101 would).
        issue(0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0);
        await_accept(0, 1'b1);
        complete(0, 0);

        // Last grant was req0, so req1 wins this contention.
        issue(0, 32'h0F0F0F0F, 32'hF0F0F0F1, 32'h00000000, 1'b1);
        issue(1, 32'h80000000, 32'h80000001, 32'h00000001, 1'b1);
        await_accept(1, 1'b1);
        complete(1, 0);
        await_accept(0, 1'b1);
        complete(0, 0);

        // Reset during the second BUSY cycle discards the operation.
        issue(1, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0);
        await_accept(1, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_valid",  rsp_valid,  0);
        check("midrst_ready0", req0_ready, 0);
        check("midrst_ready1", req1_ready, 0);
        check("midrst_sum",    rsp_sum,    0);
        check("midrst_id",     rsp_id,     0);
        check("midrst_cout",   rsp_cout,   0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("midrst_no_rsp", seen, 0);

        // Fresh contention after reset: pointer reset again favours req0.
        @(posedge clk);
        #1;
        issue(0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0);
        issue(1, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 1'b0);
        await_accept(0, 1'b1);
        complete(0, 0);
        await_accept(1, 1'b1);
        complete(1, 0);

        // A one-cycle req0 pulse during req1's BUSY is ignored.
        issue(1, 32'h00FF00FF, 32'h00010001, 32'h01000100, 1'b0);
        await_accept(1, 1'b1);
        fork
            complete(1, 0);
            begin
                @(posedge clk);
                #1;
                req0_a = 32'hDEADBEEF;
                req0_b = 32'h00000001;
                req0_valid = 1'b1;
                @(negedge clk);
                check("pulse_ready0", req0_ready, 0);
                @(posedge clk);
                #1;
                req0_valid = 1'b0;
            end
        join
        rsp_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        rsp_ready = 1'b0;
        check("pulse_not_accepted", seen, 0);

        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
